writeback_scoreboard: RTL and testbench

//   Issue-side companion of the hazard detector: tracks in-flight register writes for two execution

---
 rtl/writeback_scoreboard.sv | 109 ++++++++++
 tb/tb_writeback_scoreboard.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_scoreboard.sv
// Tracks in-flight register writes for two execution units of different latency
// and arbitrates the single write-back port, unit 1 having fixed priority.
module writeback_scoreboard #(
  parameter int unsigned LAT1  = 1,
  parameter int unsigned LAT2  = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic       issue_unit,
  input  logic [4:0] issue_row,
  output logic       issue_ready,
  input  logic       stalled,
  output logic       ass1_pending,
  output logic [4:0] ass1_row,
  output logic       ass2_pending,
  output logic [4:0] ass2_row,
  output logic       wb_valid,
  output logic [4:0] wb_row,
  output logic       wb_unit
);

  localparam int unsigned ROW_W = 5;
  localparam int unsigned NUNIT = 2;
  localparam logic [CNT_W-1:0] LAT1_M1 = CNT_W'(LAT1 - 1);
  localparam logic [CNT_W-1:0] LAT2_M1 = CNT_W'(LAT2 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } unit_state_e;

  unit_state_e            state_q [NUNIT];
  unit_state_e            state_d [NUNIT];
  logic [CNT_W-1:0]       cnt_q   [NUNIT];
  logic [CNT_W-1:0]       cnt_d   [NUNIT];
  logic [ROW_W-1:0]       row_q   [NUNIT];
  logic [ROW_W-1:0]       row_d   [NUNIT];
  logic [NUNIT-1:0]       grant;
  logic                   accept;

  // State register: reset drops any in-flight op without write-back.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int u = 0; u < NUNIT; u++) begin
        state_q[u] <= IDLE;
        cnt_q[u]   <= '0;
        row_q[u]   <= '0;
      end
    end else begin
      for (int u = 0; u < NUNIT; u++) begin
        state_q[u] <= state_d[u];
        cnt_q[u]   <= cnt_d[u];
        row_q[u]   <= row_d[u];
      end
    end
  end

  // Next-state logic for both units plus the write-back arbiter.
  always_comb begin
    for (int u = 0; u < NUNIT; u++) begin
      state_d[u] = state_q[u];
      cnt_d[u]   = cnt_q[u];
      row_d[u]   = row_q[u];
    end
    grant[0] = (state_q[0] == DONE);
    grant[1] = (state_q[1] == DONE) && !grant[0];

    issue_ready = !stalled && (state_q[issue_unit] == IDLE);
    accept      = issue_valid && issue_ready;

    for (int u = 0; u < NUNIT; u++) begin
      unique case (state_q[u])
        IDLE: begin
          if (accept && (issue_unit == 1'(u))) begin
            state_d[u] = BUSY;
            row_d[u]   = issue_row;
            cnt_d[u]   = (u == 0) ? LAT1_M1 : LAT2_M1;
          end
        end
        BUSY: begin
          if (cnt_q[u] == '0) begin
            state_d[u] = DONE;
          end else begin
            cnt_d[u] = cnt_q[u] - CNT_W'(1);
          end
        end
        DONE: begin
          if (grant[u]) begin
            state_d[u] = IDLE;
          end
        end
        default: state_d[u] = IDLE;
      endcase
    end

    ass1_pending = (state_q[0] != IDLE);
    ass2_pending = (state_q[1] != IDLE);
    ass1_row     = ass1_pending ? row_q[0] : '0;
    ass2_row     = ass2_pending ? row_q[1] : '0;

    wb_valid = grant[0] || grant[1];
    wb_unit  = grant[1];
    wb_row   = grant[0] ? row_q[0] : (grant[1] ? row_q[1] : '0);
  end

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against a timestamp-based reference model.
module tb_writeback_scoreboard;

  localparam int LAT1 = 1;
  localparam int LAT2 = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic       issue_unit;
  logic [4:0] issue_row;
  logic       issue_ready;
  logic       stalled;
  logic       ass1_pending;
  logic [4:0] ass1_row;
  logic       ass2_pending;
  logic [4:0] ass2_row;
  logic       wb_valid;
  logic [4:0] wb_row;
  logic       wb_unit;

  int errors = 0;
  int checks = 0;

  writeback_scoreboard #(.LAT1(LAT1), .LAT2(LAT2), .CNT_W(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_unit   (issue_unit),
    .issue_row    (issue_row),
    .issue_ready  (issue_ready),
    .stalled      (stalled),
    .ass1_pending (ass1_pending),
    .ass1_row     (ass1_row),
    .ass2_pending (ass2_pending),
    .ass2_row     (ass2_row),
    .wb_valid     (wb_valid),
    .wb_row       (wb_row),
    .wb_unit      (wb_unit)
  );

  always #5 clock = ~clock;

  // Reference model: each unit remembers whether it owns a write, its row and
  // the first cycle it may write back (accept cycle + latency + 1).
  bit       m_valid = 1'b0;
  bit       m_pend [2];
  bit [4:0] m_row  [2];
  int       m_rdy  [2];
  int       cyc = 0;

  function automatic bit elig(input int u);
    return m_pend[u] && (cyc >= m_rdy[u]);
  endfunction

  always @(posedge clock) begin
    bit acc;
    bit e0;
    bit e1;
    if (!reset) begin
      m_valid = 1'b1;
      for (int u = 0; u < 2; u++) begin
        m_pend[u] = 1'b0;
        m_row[u]  = '0;
        m_rdy[u]  = 0;
      end
    end else if (m_valid) begin
      acc = issue_valid && !stalled && !m_pend[issue_unit];
      e0  = elig(0);
      e1  = elig(1);
      if (e0) m_pend[0] = 1'b0;
      else if (e1) m_pend[1] = 1'b0;
      if (acc) begin
        m_pend[issue_unit] = 1'b1;
        m_row[issue_unit]  = issue_row;
        m_rdy[issue_unit]  = cyc + ((issue_unit == 1'b0) ? LAT1 : LAT2) + 1;
      end
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    bit       e0;
    bit       e1;
    bit       xwb;
    bit [4:0] xrow;
    if (m_valid) begin
      e0   = elig(0);
      e1   = elig(1);
      xwb  = e0 || e1;
      xrow = e0 ? m_row[0] : (e1 ? m_row[1] : 5'd0);
      chk("m_issue_ready", int'(issue_ready), int'(!stalled && !m_pend[issue_unit]));
      chk("m_ass1_pending", int'(ass1_pending), int'(m_pend[0]));
      chk("m_ass1_row", int'(ass1_row), m_pend[0] ? int'(m_row[0]) : 0);
      chk("m_ass2_pending", int'(ass2_pending), int'(m_pend[1]));
      chk("m_ass2_row", int'(ass2_row), m_pend[1] ? int'(m_row[1]) : 0);
      chk("m_wb_valid", int'(wb_valid), int'(xwb));
      chk("m_wb_row", int'(wb_row), int'(xrow));
      chk("m_wb_unit", int'(wb_unit), int'(!e0 && e1));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  task automatic idle_in();
    issue_valid = 1'b0;
    issue_unit  = 1'b0;
    issue_row   = 5'd0;
  endtask

  task automatic drain(input int n);
    idle_in();
    repeat (n) tick();
  endtask

  initial begin
    int cnt;
    reset   = 1'b0;
    stalled = 1'b0;
    idle_in();

    // Reset state
    tick();
    tick();
    at_neg();
    chk("rst_issue_ready", int'(issue_ready), 1);
    chk("rst_ass1_pending", int'(ass1_pending), 0);
    chk("rst_ass2_pending", int'(ass2_pending), 0);
    chk("rst_rows", int'({ass1_row, ass2_row}), 0);
    chk("rst_wb", int'({wb_valid, wb_row, wb_unit}), 0);
    tick();
    reset = 1'b1;
    tick();

    // Unit 1 single op
    issue_valid = 1'b1; issue_unit = 1'b0; issue_row = 5'b00100;
    at_neg();
    chk("s2_ready_c0", int'(issue_ready), 1);
    tick();
    idle_in();
    at_neg();
    chk("s2_pend_c1", int'(ass1_pending), 1);
    chk("s2_row_c1", int'(ass1_row), 4);
    chk("s2_wb_c1", int'(wb_valid), 0);
    tick();
    at_neg();
    chk("s2_wb_c2", int'(wb_valid), 1);
    chk("s2_wbrow_c2", int'(wb_row), 4);
    chk("s2_wbunit_c2", int'(wb_unit), 0);
    chk("s2_pend_c2", int'(ass1_pending), 1);
    tick();
    at_neg();
    chk("s2_pend_c3", int'(ass1_pending), 0);
    drain(2);

    // Simultaneous DONE: unit 1 wins, unit 2 retires one cycle later
    issue_valid = 1'b1; issue_unit = 1'b1; issue_row = 5'b00001;
    tick();
    idle_in();
    tick();
    tick();
    issue_valid = 1'b1; issue_unit = 1'b0; issue_row = 5'b10000;
    tick();
    idle_in();
    tick();
    at_neg();
    chk("s3_wb_c5", int'(wb_valid), 1);
    chk("s3_wbunit_c5", int'(wb_unit), 0);
    chk("s3_wbrow_c5", int'(wb_row), 16);
    chk("s3_pend2_c5", int'(ass2_pending), 1);
    tick();
    at_neg();
    chk("s3_wb_c6", int'(wb_valid), 1);
    chk("s3_wbunit_c6", int'(wb_unit), 1);
    chk("s3_wbrow_c6", int'(wb_row), 1);
    chk("s3_pend2_c6", int'(ass2_pending), 1);
    chk("s3_row2_c6", int'(ass2_row), 1);
    tick();
    at_neg();
    chk("s3_pend2_c7", int'(ass2_pending), 0);
    chk("s3_wb_c7", int'(wb_valid), 0);
    drain(2);

    // Stall blocks issue
    stalled = 1'b1;
    issue_valid = 1'b1; issue_unit = 1'b0; issue_row = 5'd7;
    at_neg();
    chk("s4_ready_stalled", int'(issue_ready), 0);
    tick();
    at_neg();
    chk("s4_no_accept", int'(ass1_pending), 0);
    stalled = 1'b0;
    #1;
    chk("s4_ready_unstalled", int'(issue_ready), 1);
    tick();
    idle_in();
    at_neg();
    chk("s4_pend_after", int'(ass1_pending), 1);
    chk("s4_row_after", int'(ass1_row), 7);
    drain(3);

    // Busy unit 2 holds a second request until the cycle after write-back
    issue_valid = 1'b1; issue_unit = 1'b1; issue_row = 5'd3;
    tick();
    issue_row = 5'd5;
    cnt = 0;
    at_neg();
    while (!issue_ready && cnt < 20) begin
      cnt = cnt + 1;
      tick();
      at_neg();
    end
    chk("s5_held_cycles", cnt, LAT2 + 1);
    chk("s5_ready", int'(issue_ready), 1);
    tick();
    idle_in();
    at_neg();
    chk("s5_row2", int'(ass2_row), 5);
    drain(LAT2 + 3);

    // Reset mid-operation drops the op
    issue_valid = 1'b1; issue_unit = 1'b1; issue_row = 5'd9;
    tick();
    idle_in();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    at_neg();
    chk("s6_pend2", int'(ass2_pending), 0);
    chk("s6_outs", int'({ass1_pending, ass1_row, ass2_row, wb_valid, wb_row, wb_unit}), 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      at_neg();
      if (wb_valid) cnt = cnt + 1;
    end
    chk("s6_no_wb", cnt, 0);

    // Random traffic, checked by the per-cycle model compare
    for (int i = 0; i < 3000; i++) begin
      tick();
      issue_valid = ($urandom_range(0, 99) < 60);
      issue_unit  = 1'($urandom_range(0, 1));
      issue_row   = 5'($urandom_range(0, 31));
      stalled     = ($urandom_range(0, 99) < 20);
      reset       = ($urandom_range(0, 199) != 0);
    end
    tick();
    reset = 1'b1;
    stalled = 1'b0;
    drain(8);
    at_neg();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
